// File: rtl/apb_controller.sv
// -----------------------------------------------------------------------------
// apb_controller
//
// FSM core of an AHB-to-APB bridge. It takes the decoded, pipelined AHB
// transfer information from the AHB slave interface and runs each access
// through the APB SETUP -> ENABLE sequence. It also returns Hreadyout to the
// AHB side, so the AHB master is stalled while an APB access is in SETUP.
//
// Ports
//   Hclk       in   system clock, rising edge
//   Hresetn    in   asynchronous reset, active-high (despite the name)
//   Hwrite     in   current AHB transfer direction (1 = write)
//   valid      in   current AHB transfer is valid and targets the bridge
//   Hwritereg  in   Hwrite registered one cycle
//   Haddr      in   current AHB address
//   Hwdata     in   current AHB write data
//   Haddr1     in   address pipelined one cycle
//   Haddr2     in   address pipelined two cycles
//   Hwdata1    in   write data pipelined one cycle
//   Hwdata2    in   write data pipelined two cycles (reserved, unused)
//   tempselx   in   one-hot APB slave select from the decoder
//   Pwrite     out  APB direction
//   Penable    out  APB enable strobe
//   Hreadyout  out  ready back to the AHB side
//   Pselx      out  APB slave selects
//   Pwdata     out  APB write data
//   Paddr      out  APB address
//   Prdata     out  read data, tied to zero
// -----------------------------------------------------------------------------
module apb_controller (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        valid,
    input  logic        Hwritereg,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Haddr1,
    input  logic [31:0] Haddr2,
    input  logic [31:0] Hwdata1,
    input  logic [31:0] Hwdata2,
    input  logic [2:0]  tempselx,
    output logic        Pwrite,
    output logic        Penable,
    output logic        Hreadyout,
    output logic [2:0]  Pselx,
    output logic [31:0] Pwdata,
    output logic [31:0] Paddr,
    output logic [31:0] Prdata
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WWAIT    = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        WRITEP   = 3'd4,
        RENABLE  = 3'd5,
        WENABLE  = 3'd6,
        WENABLEP = 3'd7
    } state_t;

    state_t      r_state;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    logic        r_penable;
    logic [2:0]  r_pselx;
    logic        r_hreadyout;

    state_t      w_next;
    logic [31:0] w_paddr;
    logic [31:0] w_pwdata;
    logic        w_pwrite;
    logic        w_penable;
    logic [2:0]  w_pselx;
    logic        w_hreadyout;

    // Reserved input: kept on the port list for interface compatibility only.
    logic        w_unused_hwdata2;
    assign w_unused_hwdata2 = ^Hwdata2;

    // Next state and next output values. Outputs hold unless a transition
    // explicitly loads them.
    always_comb begin
        w_next      = r_state;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_pwrite    = r_pwrite;
        w_penable   = r_penable;
        w_pselx     = r_pselx;
        w_hreadyout = r_hreadyout;

        case (r_state)
            // IDLE and both ENABLE states decide identically: the transfer
            // presented now either starts a read SETUP right away, or parks
            // in WWAIT until the write data phase arrives.
            IDLE, RENABLE, WENABLE: begin
                if (valid && !Hwrite) begin
                    w_next      = READ;
                    w_paddr     = Haddr;
                    w_pwrite    = Hwrite;
                    w_pselx     = tempselx;
                    w_penable   = 1'b0;
                    w_hreadyout = 1'b0;
                end else begin
                    w_next      = valid ? WWAIT : IDLE;
                    w_pselx     = 3'b000;
                    w_penable   = 1'b0;
                    w_hreadyout = 1'b1;
                end
            end
            // Write data is now on Hwdata; the address has moved to Haddr1.
            WWAIT: begin
                w_next      = valid ? WRITEP : WRITE;
                w_paddr     = Haddr1;
                w_pwdata    = Hwdata;
                w_pwrite    = 1'b1;
                w_pselx     = tempselx;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
            end
            READ: begin
                w_next      = RENABLE;
                w_penable   = 1'b1;
                w_hreadyout = 1'b1;
            end
            WRITE: begin
                w_next      = valid ? WENABLEP : WENABLE;
                w_penable   = 1'b1;
                w_hreadyout = 1'b1;
            end
            WRITEP: begin
                w_next      = WENABLEP;
                w_penable   = 1'b1;
                w_hreadyout = 1'b1;
            end
            // A transfer was pipelined behind the current write, so its
            // address and data are now two and one stages deep respectively.
            WENABLEP: begin
                w_paddr     = Haddr2;
                w_pselx     = tempselx;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
                if (!Hwritereg) begin
                    w_next   = READ;
                    w_pwrite = 1'b0;
                end else begin
                    w_next   = valid ? WRITEP : WRITE;
                    w_pwdata = Hwdata1;
                    w_pwrite = 1'b1;
                end
            end
            default: begin
                w_next      = IDLE;
                w_pselx     = 3'b000;
                w_penable   = 1'b0;
                w_hreadyout = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Hclk or posedge Hresetn) begin
        if (Hresetn) begin
            r_state     <= IDLE;
            r_paddr     <= 32'h0000_0000;
            r_pwdata    <= 32'h0000_0000;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_pselx     <= 3'b000;
            r_hreadyout <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_pwrite    <= w_pwrite;
            r_penable   <= w_penable;
            r_pselx     <= w_pselx;
            r_hreadyout <= w_hreadyout;
        end
    end

    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;
    assign Pwrite    = r_pwrite;
    assign Penable   = r_penable;
    assign Pselx     = r_pselx;
    assign Hreadyout = r_hreadyout;
    assign Prdata    = 32'h0000_0000;

endmodule

// File: tb/tb_apb_controller.sv
module tb_apb_controller;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        valid;
    logic        Hwritereg;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic [2:0]  tempselx;
    logic        Pwrite;
    logic        Penable;
    logic        Hreadyout;
    logic [2:0]  Pselx;
    logic [31:0] Pwdata;
    logic [31:0] Paddr;
    logic [31:0] Prdata;

    apb_controller dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .valid     (valid),
        .Hwritereg (Hwritereg),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata1   (Hwdata1),
        .Hwdata2   (Hwdata2),
        .tempselx  (tempselx),
        .Pwrite    (Pwrite),
        .Penable   (Penable),
        .Hreadyout (Hreadyout),
        .Pselx     (Pselx),
        .Pwdata    (Pwdata),
        .Paddr     (Paddr),
        .Prdata    (Prdata)
    );

    typedef struct {
        string       name;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        pwrite;
        logic        penable;
        logic [2:0]  pselx;
        logic        hready;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    event ev_chk;

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: the registered outputs change on the clock edge (or on an
    // asynchronous reset, announced via ev_chk); sample shortly afterwards.
    initial begin
        exp_t e;
        forever begin
            @(posedge Hclk or ev_chk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (Paddr !== e.paddr || Pwdata !== e.pwdata || Pwrite !== e.pwrite ||
                    Penable !== e.penable || Pselx !== e.pselx || Hreadyout !== e.hready ||
                    Prdata !== 32'h0000_0000) begin
                    bad++;
                    $display("FAIL %s: actual paddr=%h pwdata=%h pwrite=%b penable=%b pselx=%b hready=%b prdata=%h | required paddr=%h pwdata=%h pwrite=%b penable=%b pselx=%b hready=%b prdata=00000000",
                             e.name, Paddr, Pwdata, Pwrite, Penable, Pselx, Hreadyout, Prdata,
                             e.paddr, e.pwdata, e.pwrite, e.penable, e.pselx, e.hready);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [31:0] pa, input logic [31:0] pd,
                        input logic pw, input logic pe, input logic [2:0] ps, input logic hr);
        exp_t e;
        e.name = nm; e.paddr = pa; e.pwdata = pd; e.pwrite = pw;
        e.penable = pe; e.pselx = ps; e.hready = hr;
        q.push_back(e);
    endtask

    // One clock of stimulus plus the output values expected after the edge.
    task automatic cyc(input string nm, input logic v, input logic hw, input logic hwr,
                       input logic [31:0] ha, input logic [31:0] hwd, input logic [31:0] ha1,
                       input logic [31:0] ha2, input logic [31:0] hwd1, input logic [2:0] sel,
                       input logic [31:0] pa, input logic [31:0] pd, input logic pw,
                       input logic pe, input logic [2:0] ps, input logic hr);
        @(negedge Hclk);
        valid = v; Hwrite = hw; Hwritereg = hwr; Haddr = ha; Hwdata = hwd;
        Haddr1 = ha1; Haddr2 = ha2; Hwdata1 = hwd1; tempselx = sel;
        Hwdata2 = 32'hDEAD_BEEF;
        push(nm, pa, pd, pw, pe, ps, hr);
    endtask

    // Assert reset between edges and expect reset values without a clock.
    task automatic async_reset(input string nm);
        @(negedge Hclk);
        #1;
        valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
        Hresetn = 1'b1;
        push(nm, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1);
        ->ev_chk;
        @(negedge Hclk);
        Hresetn = 1'b0;
    endtask

    initial begin
        Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Hwritereg = 1'b0;
        Haddr = 32'h0; Hwdata = 32'h0; Haddr1 = 32'h0; Haddr2 = 32'h0;
        Hwdata1 = 32'h0; Hwdata2 = 32'h0; tempselx = 3'b000;

        // Reset and idle
        async_reset("reset_async");
        cyc("idle_hold0", 0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h0,32'h0,0,0,3'b000,1);
        cyc("idle_hold1", 0,0,0, 32'h1234_0000,32'h0,32'h0,32'h0,32'h0,3'b111, 32'h0,32'h0,0,0,3'b000,1);

        // Single read
        cyc("rd_setup",   1,0,0, 32'h8040_0000,32'h0,32'h0,32'h0,32'h0,3'b010, 32'h8040_0000,32'h0,0,0,3'b010,0);
        cyc("rd_enable",  0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h8040_0000,32'h0,0,1,3'b010,1);
        cyc("rd_idle",    0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h8040_0000,32'h0,0,0,3'b000,1);

        // Single write
        cyc("wr_wwait",   1,1,0, 32'h0,32'h0,32'h8040_0000,32'h0,32'h0,3'b001, 32'h8040_0000,32'h0,0,0,3'b000,1);
        cyc("wr_setup",   0,0,1, 32'h0,32'h8500_0000,32'h8040_0000,32'h0,32'h0,3'b001, 32'h8040_0000,32'h8500_0000,1,0,3'b001,0);
        cyc("wr_enable",  0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h8040_0000,32'h8500_0000,1,1,3'b001,1);
        cyc("wr_idle",    0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h8040_0000,32'h8500_0000,1,0,3'b000,1);

        // Back-to-back writes
        cyc("b2b_wwait",  1,1,0, 32'h0,32'h1111_0000,32'h9000_0000,32'h0,32'h0,3'b100, 32'h8040_0000,32'h8500_0000,1,0,3'b000,1);
        cyc("b2b_setup1", 1,1,1, 32'h0,32'h1111_0000,32'h9000_0000,32'h0,32'h0,3'b100, 32'h9000_0000,32'h1111_0000,1,0,3'b100,0);
        cyc("b2b_en1",    1,1,1, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b100, 32'h9000_0000,32'h1111_0000,1,1,3'b100,1);
        cyc("b2b_setup2", 1,1,1, 32'h0,32'h0,32'h0,32'h9000_1111,32'h2222_0000,3'b010, 32'h9000_1111,32'h2222_0000,1,0,3'b010,0);
        cyc("b2b_en2",    1,0,1, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b010, 32'h9000_1111,32'h2222_0000,1,1,3'b010,1);

        // Write followed by read (WENABLEP with Hwritereg=0)
        cyc("wr2rd_setup",1,0,0, 32'h0,32'h0,32'h0,32'h8000_0044,32'h5555_5555,3'b001, 32'h8000_0044,32'h2222_0000,0,0,3'b001,0);
        cyc("wr2rd_en",   0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h8000_0044,32'h2222_0000,0,1,3'b001,1);
        cyc("wr2rd_idle", 0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h8000_0044,32'h2222_0000,0,0,3'b000,1);

        // Read -> read, read -> write, pipelined write ending with WENABLEP -> WRITE
        cyc("rr_setup1",  1,0,0, 32'h1234_5678,32'h0,32'h0,32'h0,32'h0,3'b100, 32'h1234_5678,32'h2222_0000,0,0,3'b100,0);
        cyc("rr_en1",     0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h1234_5678,32'h2222_0000,0,1,3'b100,1);
        cyc("rr_setup2",  1,0,0, 32'h2000_0000,32'h0,32'h0,32'h0,32'h0,3'b010, 32'h2000_0000,32'h2222_0000,0,0,3'b010,0);
        cyc("rr_en2",     0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h2000_0000,32'h2222_0000,0,1,3'b010,1);
        cyc("rw_wwait",   1,1,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b001, 32'h2000_0000,32'h2222_0000,0,0,3'b000,1);
        cyc("rw_setup",   1,1,1, 32'h0,32'h3333_3333,32'h3000_0000,32'h0,32'h0,3'b001, 32'h3000_0000,32'h3333_3333,1,0,3'b001,0);
        cyc("rw_enp",     0,0,1, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h3000_0000,32'h3333_3333,1,1,3'b001,1);
        cyc("wp2w_setup", 0,0,1, 32'h0,32'h0,32'h0,32'h4000_0000,32'h4444_4444,3'b100, 32'h4000_0000,32'h4444_4444,1,0,3'b100,0);
        cyc("wp2w_en",    0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h4000_0000,32'h4444_4444,1,1,3'b100,1);

        // Reset while in WENABLE with Penable=1, then restart from IDLE
        async_reset("reset_mid");
        cyc("post_idle",  0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h0,32'h0,0,0,3'b000,1);
        cyc("post_setup", 1,0,0, 32'h5000_0000,32'h0,32'h0,32'h0,32'h0,3'b001, 32'h5000_0000,32'h0,0,0,3'b001,0);
        cyc("post_en",    0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h5000_0000,32'h0,0,1,3'b001,1);
        cyc("post_idle2", 0,0,0, 32'h0,32'h0,32'h0,32'h0,32'h0,3'b000, 32'h5000_0000,32'h0,0,0,3'b000,1);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge Hclk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: actual pending=%0d required pending=0", q.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
